pixel_write_controller: RTL and testbench

Consumer end of the line-drawing coordinate stream. Accepts signed (x,y) pixel coordinates from the line generator over a valid/ready handshake and buffers them in a small FIFO. Clips off-screen points, converts each surviving point to a linear framebuffer address, and issues single-word writes to the framebuffer port with wait-state stalling. Signals completion once the last pixel of a line has been written.

---
 rtl/pixel_write_controller.sv | 138 +++++++++++++
 tb/tb_pixel_write_controller.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_controller.sv
// Pixel write controller: buffers signed (x,y) points, clips them to the screen and issues framebuffer writes.
// Optional CLIP_STATS_EN adds a saturating clip_count output.
module pixel_write_controller #(
  parameter int COORD_W    = 13,
  parameter int FB_WIDTH   = 640,
  parameter int FB_HEIGHT  = 480,
  parameter int ADDR_W     = 19,
  parameter int COLOR_W    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [COLOR_W-1:0]        color,
  input  logic                      pix_valid,
  input  logic signed [COORD_W-1:0] pix_x,
  input  logic signed [COORD_W-1:0] pix_y,
  input  logic                      pix_last,
  output logic                      pix_ready,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [COLOR_W-1:0]        mem_data,
  input  logic                      mem_wait,
  output logic                      busy,
  output logic                      done,
`ifdef CLIP_STATS_EN
  output logic [15:0]               clip_count,
`endif
  output logic [1:0]                dbg_state
);

  // Handshake: a coordinate transfers on a rising edge where pix_valid && pix_ready;
  // a framebuffer write completes on a rising edge where mem_we && !mem_wait.

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(FB_WIDTH);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(FB_HEIGHT);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, FINISH = 2'd3} state_t;

  state_t               state, state_nxt;
  logic [COLOR_W-1:0]   color_reg;
  logic [COORD_W-1:0]   fifo_x [FIFO_DEPTH];
  logic [COORD_W-1:0]   fifo_y [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       count;
  logic                 fifo_full, fifo_empty;
  logic                 stage_free, push, pop;
  logic [COORD_W-1:0]   head_x, head_y;
  logic                 in_bounds;
  logic [ADDR_W-1:0]    head_addr;

  assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign stage_free = !mem_we || !mem_wait;
  assign push       = pix_valid && pix_ready;
  assign pop        = (state != IDLE) && !fifo_empty && stage_free;
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

  assign head_x    = fifo_x[rd_ptr];
  assign head_y    = fifo_y[rd_ptr];
  // MSB clear means non-negative, so the remaining compare can be unsigned.
  assign in_bounds = !head_x[COORD_W-1] && (head_x < X_LIM) &&
                     !head_y[COORD_W-1] && (head_y < Y_LIM);
  assign head_addr = ADDR_W'(head_y) * ADDR_W'(FB_WIDTH) + ADDR_W'(head_x);

  always_comb begin
    state_nxt = state;
    pix_ready = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN: begin
        pix_ready = !fifo_full;
        if (pix_valid && !fifo_full && pix_last) state_nxt = DRAIN;
      end
      DRAIN:   if (fifo_empty && stage_free) state_nxt = FINISH;
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_x[wr_ptr] <= pix_x;
      fifo_y[wr_ptr] <= pix_y;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      color_reg <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) color_reg <= color;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      // A stalled write holds everything; otherwise the stage reloads or goes idle.
      if (state == IDLE) begin
        mem_we <= 1'b0;
      end else if (stage_free) begin
        if (pop && in_bounds) begin
          mem_we   <= 1'b1;
          mem_addr <= head_addr;
          mem_data <= color_reg;
        end else begin
          mem_we <= 1'b0;
        end
      end
    end
  end

`ifdef CLIP_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      clip_count <= '0;
    end else if (state == IDLE && start) begin
      clip_count <= '0;
    end else if (pop && !in_bounds && clip_count != 16'hFFFF) begin
      clip_count <= clip_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_write_controller.sv
// Bench for pixel_write_controller: directed lines checked against a queue-based write model.
// Build with CLIP_STATS_EN defined to also exercise clip_count.
module tb_pixel_write_controller;

  localparam int COORD_W = 13;
  localparam int ADDR_W  = 19;
  localparam int COLOR_W = 8;
  localparam int FBW     = 640;
  localparam int FBH     = 480;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic [COLOR_W-1:0]  color = '0;
  logic                pix_valid = 1'b0;
  logic [COORD_W-1:0]  pix_x = '0;
  logic [COORD_W-1:0]  pix_y = '0;
  logic                pix_last = 1'b0;
  logic                pix_ready;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [COLOR_W-1:0]  mem_data;
  logic                mem_wait = 1'b0;
  logic                busy;
  logic                done;
  logic [1:0]          dbg_state;
`ifdef CLIP_STATS_EN
  logic [15:0]         clip_count;
`endif

  pixel_write_controller dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .color     (color),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_last  (pix_last),
    .pix_ready (pix_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_wait  (mem_wait),
    .busy      (busy),
    .done      (done),
`ifdef CLIP_STATS_EN
    .clip_count(clip_count),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic [ADDR_W+COLOR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0]         wr_addr_log[$];
  logic [COLOR_W-1:0]        wr_data_log[$];
  int                        wr_cyc_log[$];
  int                        acc_cyc_log[$];
  logic [COLOR_W-1:0]        cur_color = '0;
  int                        done_cnt = 0;
  int                        mx, my;
  logic [ADDR_W+COLOR_W-1:0] e;
  logic                      prev_stall = 1'b0;
  logic [ADDR_W-1:0]         prev_addr;
  logic [COLOR_W-1:0]        prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Model: every accepted on-screen point becomes one write of y*FBW+x with the line colour,
  // in acceptance order; off-screen points produce nothing.
  always @(negedge clk) begin
    if (reset) begin
      if (pix_valid && pix_ready) begin
        mx = int'($signed(pix_x));
        my = int'($signed(pix_y));
        acc_cyc_log.push_back(cyc);
        if (mx >= 0 && mx < FBW && my >= 0 && my < FBH)
          exp_q.push_back({ADDR_W'(my * FBW + mx), cur_color});
      end
      if (prev_stall) begin
        check("stall_hold_we", mem_we, 1);
        check("stall_hold_addr", mem_addr, prev_addr);
        check("stall_hold_data", mem_data, prev_data);
      end
      if (mem_we && !mem_wait) begin
        wr_addr_log.push_back(mem_addr);
        wr_data_log.push_back(mem_data);
        wr_cyc_log.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write actual_addr=%0d required=no write", mem_addr);
        end else begin
          e = exp_q.pop_front();
          if (mem_addr !== e[ADDR_W+COLOR_W-1:COLOR_W] || mem_data !== e[COLOR_W-1:0]) begin
            failures++;
            $display("FAIL write_order actual=%0d/%0h required=%0d/%0h",
                     mem_addr, mem_data, e[ADDR_W+COLOR_W-1:COLOR_W], e[COLOR_W-1:0]);
          end
        end
      end
      if (done) begin
        done_cnt++;
        check("done_all_written", exp_q.size(), 0);
      end
      prev_stall = mem_we && mem_wait;
      prev_addr  = mem_addr;
      prev_data  = mem_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_line(input logic [COLOR_W-1:0] c);
    wr_addr_log.delete();
    wr_data_log.delete();
    wr_cyc_log.delete();
    acc_cyc_log.delete();
    done_cnt  = 0;
    cur_color = c;
    color     = c;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_point(input int x, input int y, input logic last);
    int n;
    n = 0;
    pix_valid = 1'b1;
    pix_x     = COORD_W'(x);
    pix_y     = COORD_W'(y);
    pix_last  = last;
    forever begin
      @(negedge clk);
      if (pix_ready) break;
      n++;
      if (n > 200) begin
        check("accept_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 300);
    check({name, "_done_seen"}, done, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check({name, "_idle_busy"}, busy, 0);
    check({name, "_done_low"}, done, 0);
    repeat (3) @(negedge clk);
    check({name, "_done_once"}, done_cnt, 1);
    @(posedge clk); #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    // Reset / idle
    pix_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pix_ready", pix_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, 0);
`ifdef CLIP_STATS_EN
    check("rst_clip_count", clip_count, 0);
`endif
    reset = 1'b1;
    @(negedge clk);
    check("idle_ready_low", pix_ready, 0);
    check("idle_busy_low", busy, 0);
    @(posedge clk); #1;
    pix_valid = 1'b0;

    // Basic line
    start_line(8'h5A);
    check("run_busy", busy, 1);
    check("run_ready", pix_ready, 1);
    send_point(3, 2, 1'b0);
    send_point(4, 2, 1'b0);
    send_point(5, 3, 1'b1);
    wait_done("basic");
    check("basic_nwrites", wr_addr_log.size(), 3);
    if (wr_addr_log.size() == 3) begin
      check("basic_addr0", wr_addr_log[0], 1283);
      check("basic_addr1", wr_addr_log[1], 1284);
      check("basic_addr2", wr_addr_log[2], 1925);
      check("basic_data2", wr_data_log[2], 8'h5A);
      check("basic_latency", wr_cyc_log[0] - acc_cyc_log[0], 2);
      check("basic_back_to_back", wr_cyc_log[2] - wr_cyc_log[0], 2);
    end

    // Backpressure
    mem_wait = 1'b1;
    start_line(8'h33);
    for (int i = 0; i < 5; i++) send_point(i, 1, 1'b0);
    pix_valid = 1'b1;
    pix_x     = COORD_W'(5);
    pix_y     = COORD_W'(2);
    pix_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_ready_low", pix_ready, 0);
      check("bp_we_held", mem_we, 1);
      check("bp_addr_held", mem_addr, 640);
    end
    @(posedge clk); #1;
    mem_wait = 1'b0;
    send_point(5, 2, 1'b1);
    wait_done("bp");
    check("bp_nwrites", wr_addr_log.size(), 6);
    if (wr_addr_log.size() == 6) begin
      check("bp_addr0", wr_addr_log[0], 640);
      check("bp_addr4", wr_addr_log[4], 644);
      check("bp_addr5", wr_addr_log[5], 1285);
      check("bp_data5", wr_data_log[5], 8'h33);
    end

    // Clipping
    start_line(8'hC3);
    send_point(-1, 0, 1'b0);
    send_point(640, 5, 1'b0);
    send_point(10, 480, 1'b0);
    send_point(639, 479, 1'b1);
    wait_done("clip");
    check("clip_nwrites", wr_addr_log.size(), 1);
    if (wr_addr_log.size() == 1) begin
      check("clip_addr", wr_addr_log[0], 307199);
      check("clip_data", wr_data_log[0], 8'hC3);
    end
`ifdef CLIP_STATS_EN
    check("clip_count", clip_count, 3);
`endif

    // Reset mid-line with a stalled write and three queued points
    mem_wait = 1'b1;
    start_line(8'h11);
    send_point(1, 1, 1'b0);
    send_point(2, 1, 1'b0);
    send_point(3, 1, 1'b0);
    send_point(4, 1, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", dbg_state, 0);
    check("mid_rst_ready", pix_ready, 0);
    exp_q.delete();
    reset    = 1'b1;
    mem_wait = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_rst_no_done", done_cnt, 0);
    check("mid_rst_no_write", wr_addr_log.size(), 0);
    @(posedge clk); #1;
    // Single-point line afterwards proves the FIFO was emptied.
    start_line(8'h22);
    send_point(7, 7, 1'b1);
    wait_done("single");
    check("single_nwrites", wr_addr_log.size(), 1);
    if (wr_addr_log.size() == 1) begin
      check("single_addr", wr_addr_log[0], 4487);
      check("single_data", wr_data_log[0], 8'h22);
    end

    // Start during RUN is ignored
    start_line(8'h4C);
    send_point(0, 3, 1'b0);
    start = 1'b1;
    color = 8'hFF;
    send_point(1, 3, 1'b0);
    start = 1'b0;
    send_point(2, 3, 1'b1);
    wait_done("restart");
    check("restart_nwrites", wr_addr_log.size(), 3);
    if (wr_addr_log.size() == 3) begin
      check("restart_data1", wr_data_log[1], 8'h4C);
      check("restart_data2", wr_data_log[2], 8'h4C);
      check("restart_addr2", wr_addr_log[2], 1922);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
